// File: rtl/dram_pack_pkg.sv
// Sizing helpers and FSM state encoding shared by the DRAM-to-memory packer.
package dram_pack_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } pack_state_e;

   // Beats needed to cover one output word.
   function automatic int calc_k(input int in_w, input int out_w);
      return (out_w + in_w - 1) / in_w;
   endfunction

   function automatic int calc_acc_w(input int in_w, input int out_w);
      return calc_k(in_w, out_w) * in_w;
   endfunction

   function automatic int calc_aw(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   // Beat counter only ever holds 0..K-1.
   function automatic int calc_cnt_w(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/dram_pack_addr_gen.sv
// Round-robin bank selector and per-bank write address; the address advances
// once every bank has taken a word and pulses wrap_o when it rolls over to 0.
module dram_pack_addr_gen
   import dram_pack_pkg::*;
#(
   parameter int NUM_BANKS = 4,
   parameter int DEPTH     = 512,
   parameter int AW        = calc_aw(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 fire_i,
   output logic [NUM_BANKS-1:0] we_o,
   output logic [AW-1:0]        addr_o,
   output logic                 wrap_o
);

   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic [BW-1:0] bank_q, bank_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          wrap_q, wrap_d;

   always_comb begin
      bank_d = bank_q;
      addr_d = addr_q;
      wrap_d = 1'b0;
      if (fire_i) begin
         if (bank_q == BW'(NUM_BANKS - 1)) begin
            bank_d = '0;
            if (addr_q == AW'(DEPTH - 1)) begin
               addr_d = '0;
               wrap_d = 1'b1;
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end else begin
            bank_d = bank_q + BW'(1);
         end
      end
   end

   always_comb begin
      we_o = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         we_o[b] = fire_i && (bank_q == BW'(b));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bank_q <= '0;
         addr_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bank_q <= bank_d;
         addr_q <= addr_d;
         wrap_q <= wrap_d;
      end
   end

   assign addr_o = addr_q;
   assign wrap_o = wrap_q;

endmodule

// File: rtl/dram_to_memory_packer.sv
// Packs IN_W-bit DRAM beats MSB-first into OUT_W-bit words written round-robin
// across NUM_BANKS banks. Define DRAM_PACKER_BYTE_SWAP_EN to byte-reverse each beat.
module dram_to_memory_packer
   import dram_pack_pkg::*;
#(
   parameter int  IN_W      = 32,
   parameter int  OUT_W     = 163,
   parameter int  NUM_BANKS = 4,
   parameter int  DEPTH     = 512,
   localparam int AW        = calc_aw(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 dram_packer_rst_i,
   input  logic [IN_W-1:0]      in_data_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic                 flush_i,
   output logic [OUT_W-1:0]     mem_data_o,
   output logic                 mem_valid_o,
   input  logic                 mem_ready_i,
   output logic [NUM_BANKS-1:0] mem_we_o,
   output logic [AW-1:0]        mem_addr_o,
   output logic                 wrap_o,
   output logic                 flush_done_o
);

   localparam int K     = calc_k(IN_W, OUT_W);
   localparam int ACC_W = calc_acc_w(IN_W, OUT_W);
   localparam int CNT_W = calc_cnt_w(K);

   if (IN_W < 1 || OUT_W < 1 || NUM_BANKS < 1 || DEPTH < 1) begin : g_param_chk
      $error("dram_to_memory_packer: IN_W, OUT_W, NUM_BANKS and DEPTH must all be >= 1");
   end

   pack_state_e      state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             flush_done_q, flush_done_d;

   logic [IN_W-1:0]  beat;
   logic [ACC_W-1:0] acc_shift;
   logic [ACC_W-1:0] flush_shift;
   logic [OUT_W-1:0] full_word;
   logic [OUT_W-1:0] flush_word;
   logic             out_free;
   logic             fire;
   logic             accept;
   logic             word_done;

`ifdef DRAM_PACKER_BYTE_SWAP_EN
   if ((IN_W % 8) != 0) begin : g_swap_chk
      $error("dram_to_memory_packer: byte swap needs IN_W to be a multiple of 8");
   end

   always_comb begin
      beat = in_data_i;
      for (int i = 0; i < IN_W / 8; i++) begin
         beat[8*i +: 8] = in_data_i[IN_W-8-8*i +: 8];
      end
   end
`else
   assign beat = in_data_i;
`endif

   if (K == 1) begin : g_k1
      assign acc_shift = beat;
   end else begin : g_kn
      assign acc_shift = {acc_q[ACC_W-IN_W-1:0], beat};
   end

   // Older beats above the live ones fall off the top, leaving zero padding below.
   assign flush_shift = acc_q << (IN_W * (K - int'(cnt_q)));
   assign flush_word  = OUT_W'(flush_shift >> (ACC_W - OUT_W));
   assign full_word   = OUT_W'(acc_shift >> (ACC_W - OUT_W));

   assign out_free   = ~valid_q | mem_ready_i;
   assign fire       = valid_q & mem_ready_i & ~dram_packer_rst_i;
   assign in_ready_o = dram_packer_rst_i | ((state_q == ST_ACCUM) & out_free);
   assign accept     = in_valid_i & in_ready_o & ~dram_packer_rst_i;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      valid_d      = valid_q & ~mem_ready_i;
      flush_done_d = 1'b0;
      word_done    = 1'b0;
      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               acc_d = acc_shift;
               if (cnt_q == CNT_W'(K - 1)) begin
                  cnt_d     = '0;
                  data_d    = full_word;
                  valid_d   = 1'b1;
                  word_done = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            // A flush that coincides with a completed word just waits for it.
            if (flush_i) begin
               if (word_done) begin
                  state_d = ST_DRAIN;
               end else if (cnt_d != '0) begin
                  state_d = ST_FLUSH;
               end else begin
                  flush_done_d = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            if (out_free) begin
               data_d  = flush_word;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fire) begin
               flush_done_d = 1'b1;
               state_d      = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (dram_packer_rst_i) begin
         state_q      <= ST_ACCUM;
         acc_q        <= '0;
         cnt_q        <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         flush_done_q <= flush_done_d;
      end
   end

   dram_pack_addr_gen #(
      .NUM_BANKS (NUM_BANKS),
      .DEPTH     (DEPTH),
      .AW        (AW)
   ) u_addr_gen (
      .clk_i  (clk_i),
      .rst_i  (dram_packer_rst_i),
      .fire_i (fire),
      .we_o   (mem_we_o),
      .addr_o (mem_addr_o),
      .wrap_o (wrap_o)
   );

   assign mem_data_o   = data_q;
   assign mem_valid_o  = valid_q;
   assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_dram_to_memory_packer.sv
// Bench for dram_to_memory_packer: directed literal cases plus randomized traffic
// checked every cycle against a beat-queue reference model.
module tb_dram_to_memory_packer;

   localparam int IN_W  = 32;
   localparam int OUT_W = 72;
   localparam int NB    = 4;
   localparam int DEPTH = 4;
   localparam int K     = 3;
   localparam int ACC_W = K * IN_W;
   localparam int AW    = 2;

   logic              clk_i;
   logic              rst;
   logic [IN_W-1:0]   in_data_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic              flush_i;
   logic [OUT_W-1:0]  mem_data_o;
   logic              mem_valid_o;
   logic              mem_ready_i;
   logic [NB-1:0]     mem_we_o;
   logic [AW-1:0]     mem_addr_o;
   logic              wrap_o;
   logic              flush_done_o;

   int checks   = 0;
   int failures = 0;

   dram_to_memory_packer #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .NUM_BANKS (NB),
      .DEPTH     (DEPTH)
   ) dut (
      .clk_i             (clk_i),
      .dram_packer_rst_i (rst),
      .in_data_i         (in_data_i),
      .in_valid_i        (in_valid_i),
      .in_ready_o        (in_ready_o),
      .flush_i           (flush_i),
      .mem_data_o        (mem_data_o),
      .mem_valid_o       (mem_valid_o),
      .mem_ready_i       (mem_ready_i),
      .mem_we_o          (mem_we_o),
      .mem_addr_o        (mem_addr_o),
      .wrap_o            (wrap_o),
      .flush_done_o      (flush_done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: beats of the open word, the pending output word, writes so far.
   logic [IN_W-1:0]  m_part[$];
   logic             m_valid = 1'b0;
   logic [OUT_W-1:0] m_data  = '0;
   int               m_mode  = 0;   // 0 packing, 1 flush word not yet loaded, 2 waiting for last write
   int               m_nwr   = 0;
   logic             m_wrap  = 1'b0;
   logic             m_fd    = 1'b0;
   int               wrap_seen = 0;

   function automatic logic [IN_W-1:0] model_beat(input logic [IN_W-1:0] d);
`ifdef DRAM_PACKER_BYTE_SWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction

   function automatic logic [OUT_W-1:0] pack_word(input logic [IN_W-1:0] beats[$]);
      logic [ACC_W-1:0] big;
      big = '0;
      foreach (beats[i]) big[ACC_W-1-i*IN_W -: IN_W] = beats[i];
      return OUT_W'(big >> (ACC_W - OUT_W));
   endfunction

   logic          fire_m, exp_rdy, done_word;
   logic [NB-1:0] exp_we;
   int            mode0;

   always @(negedge clk_i) begin
      fire_m  = !rst && m_valid && mem_ready_i;
      exp_rdy = rst || (m_mode == 0 && (!m_valid || mem_ready_i));
      exp_we  = fire_m ? (NB'(1) << (m_nwr % NB)) : '0;
      check("in_ready", 128'(in_ready_o), 128'(exp_rdy));
      check("mem_valid", 128'(mem_valid_o), 128'(m_valid));
      if (m_valid) check("mem_data", 128'(mem_data_o), 128'(m_data));
      check("mem_we", 128'(mem_we_o), 128'(exp_we));
      check("mem_addr", 128'(mem_addr_o), 128'((m_nwr / NB) % DEPTH));
      check("wrap", 128'(wrap_o), 128'(m_wrap));
      check("flush_done", 128'(flush_done_o), 128'(m_fd));
      if (rst) begin
         m_part.delete();
         m_valid = 1'b0; m_data = '0; m_mode = 0; m_nwr = 0;
         m_wrap = 1'b0; m_fd = 1'b0; wrap_seen = 0;
      end else begin
         if (wrap_o) wrap_seen++;
         mode0 = m_mode;
         done_word = 1'b0;
         m_wrap = 1'b0;
         m_fd = 1'b0;
         if (fire_m) begin
            m_nwr++;
            m_valid = 1'b0;
            if (m_nwr % (NB * DEPTH) == 0) m_wrap = 1'b1;
            if (mode0 == 2) begin
               m_fd = 1'b1;
               m_mode = 0;
            end
         end
         if (mode0 == 1) begin
            if (!m_valid) begin
               m_data = pack_word(m_part);
               m_part.delete();
               m_valid = 1'b1;
               m_mode = 2;
            end
         end else if (mode0 == 0) begin
            if (in_valid_i && exp_rdy) begin
               m_part.push_back(model_beat(in_data_i));
               if (m_part.size() == K) begin
                  m_data = pack_word(m_part);
                  m_part.delete();
                  m_valid = 1'b1;
                  done_word = 1'b1;
               end
            end
            if (flush_i) begin
               if (done_word) m_mode = 2;
               else if (m_part.size() != 0) m_mode = 1;
               else m_fd = 1'b1;
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic f, input logic mr);
      in_valid_i = v; in_data_i = d; flush_i = f; mem_ready_i = mr;
      @(posedge clk_i); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rst = 1'b0;
   endtask

   task automatic settle();
      in_valid_i = 1'b0; flush_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic next_cycle();
      @(posedge clk_i); #1;
   endtask

   int stall;

   initial begin
      rst = 1'b1; in_valid_i = 1'b0; in_data_i = '0; flush_i = 1'b0; mem_ready_i = 1'b1;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("rst_data", 128'(mem_data_o), 128'(0));
      check("rst_valid", 128'(mem_valid_o), 128'(0));
      check("rst_we", 128'(mem_we_o), 128'(0));
      check("rst_addr", 128'(mem_addr_o), 128'(0));
      check("rst_ready", 128'(in_ready_o), 128'(1));
      next_cycle();

      // Three beats form one word.
      do_reset();
      drive(1'b1, 32'h11111111, 1'b0, 1'b1);
      drive(1'b1, 32'h22222222, 1'b0, 1'b1);
      drive(1'b1, 32'h33333333, 1'b0, 1'b1);
      settle();
      check("t1_valid", 128'(mem_valid_o), 128'(1));
      check("t1_data", 128'(mem_data_o), 128'(72'h111111112222222233));
      check("t1_we", 128'(mem_we_o), 128'(4'b0001));
      check("t1_addr", 128'(mem_addr_o), 128'(0));
      next_cycle();

      // Partial word flush with zero padding.
      do_reset();
      drive(1'b1, 32'h11111111, 1'b0, 1'b1);
      drive(1'b1, 32'h22222222, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b1);
      settle();
      check("t2_data", 128'(mem_data_o), 128'(72'h111111112222222200));
      check("t2_we", 128'(mem_we_o), 128'(4'b0001));
      check("t2_fd_early", 128'(flush_done_o), 128'(0));
      next_cycle();
      settle();
      check("t2_fd", 128'(flush_done_o), 128'(1));
      check("t2_valid_after", 128'(mem_valid_o), 128'(0));
      next_cycle();

      // Flush with nothing buffered.
      do_reset();
      drive(1'b0, '0, 1'b1, 1'b1);
      settle();
      check("t3_fd", 128'(flush_done_o), 128'(1));
      check("t3_valid", 128'(mem_valid_o), 128'(0));
      next_cycle();

      // Flush together with the completing beat.
      do_reset();
      drive(1'b1, 32'h11111111, 1'b0, 1'b1);
      drive(1'b1, 32'h22222222, 1'b0, 1'b1);
      drive(1'b1, 32'h33333333, 1'b1, 1'b1);
      settle();
      check("t4_data", 128'(mem_data_o), 128'(72'h111111112222222233));
      check("t4_fd_early", 128'(flush_done_o), 128'(0));
      next_cycle();
      settle();
      check("t4_fd", 128'(flush_done_o), 128'(1));
      next_cycle();

      // Sink stalled for ten cycles with beats offered.
      do_reset();
      drive(1'b1, 32'h77777777, 1'b0, 1'b1);
      drive(1'b1, 32'h88888888, 1'b0, 1'b1);
      drive(1'b1, 32'h99999999, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
      settle();
      check("t5_valid", 128'(mem_valid_o), 128'(1));
      check("t5_data", 128'(mem_data_o), 128'(72'h777777778888888899));
      check("t5_ready", 128'(in_ready_o), 128'(0));
      next_cycle();
      for (int i = 0; i < 8; i++) drive(1'b1, $urandom, 1'b0, 1'b1);

      // 17 writes through a 4x4 bank/address space.
      do_reset();
      for (int i = 0; i < 51; i++) drive(1'b1, $urandom, 1'b0, 1'b1);
      settle();
      check("t6_we", 128'(mem_we_o), 128'(4'b0001));
      check("t6_addr", 128'(mem_addr_o), 128'(0));
      check("t6_wraps", 128'(wrap_seen), 128'(1));
      next_cycle();

      // Reset in the middle of a word.
      do_reset();
      drive(1'b1, 32'hAAAAAAAA, 1'b0, 1'b1);
      drive(1'b1, 32'hBBBBBBBB, 1'b0, 1'b1);
      do_reset();
      drive(1'b1, 32'h44444444, 1'b0, 1'b1);
      drive(1'b1, 32'h55555555, 1'b0, 1'b1);
      drive(1'b1, 32'h66666666, 1'b0, 1'b1);
      settle();
      check("t7_data", 128'(mem_data_o), 128'(72'h444444445555555566));
      check("t7_addr", 128'(mem_addr_o), 128'(0));
      next_cycle();

      // Beat byte order.
      do_reset();
      drive(1'b1, 32'hAABBCCDD, 1'b0, 1'b1);
      drive(1'b1, '0, 1'b0, 1'b1);
      drive(1'b1, '0, 1'b0, 1'b1);
      settle();
`ifdef DRAM_PACKER_BYTE_SWAP_EN
      check("t8_swap", 128'(mem_data_o), 128'(72'hDDCCBBAA0000000000));
`else
      check("t8_noswap", 128'(mem_data_o), 128'(72'hAABBCCDD0000000000));
`endif
      next_cycle();

      // Randomized traffic with stalls, flushes and occasional resets.
      do_reset();
      stall = 0;
      for (int c = 0; c < 4000; c++) begin
         if (stall > 0) stall--;
         else if ($urandom_range(0, 40) == 0) stall = $urandom_range(3, 12);
         rst         = ($urandom_range(0, 300) == 0);
         in_valid_i  = ($urandom_range(0, 3) != 0);
         in_data_i   = $urandom;
         flush_i     = ($urandom_range(0, 12) == 0);
         mem_ready_i = (stall == 0) && ($urandom_range(0, 3) != 0);
         next_cycle();
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
